// File: rtl/tiger_icache_pkg.sv
// Shared instruction-cache definitions: line geometry and fill-buffer state encoding.
// The read-side mux, the icache controller and the fill buffer all take their
// default geometry from here so that it has a single source.
package tiger_icache_pkg;

    // Default line geometry: word width, words per line, word-select width.
    localparam int unsigned IcacheN = 32;
    localparam int unsigned IcacheM = 8;
    localparam int unsigned IcacheS = 3;

    // Fill-buffer control states (binary encoded).
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDone = 2'd2
    } fill_state_e;

endpackage

// File: rtl/tiger_icache_line_demux.sv
// Decodes a word slot index into M one-hot word write enables for the line register.
module tiger_icache_line_demux #(
    parameter int unsigned M = 8,
    parameter int unsigned S = 3
) (
    input  logic [S-1:0] slot,
    input  logic         we,
    output logic [M-1:0] en
);

    // One enable per word; at most one is high, and only while we is high.
    always_comb begin
        en = '0;
        for (int unsigned k = 0; k < M; k++) begin
            en[k] = we && (slot == S'(k));
        end
    end

endmodule

// File: rtl/tiger_icache_fill_buffer.sv
// Instruction-cache line fill buffer.
// Assembles one line from a critical-word-first wrapping memory burst, forwards the
// first beat early, and offers the finished line to the data RAM with valid/ready.
module tiger_icache_fill_buffer
    import tiger_icache_pkg::*;
#(
    parameter int unsigned N = IcacheN,
    parameter int unsigned M = IcacheM,
    parameter int unsigned S = IcacheS,
    parameter int unsigned W = M * N
) (
    input  logic         csi_clockreset_clk,
    input  logic         csi_clockreset_reset_n,
    input  logic         fill_start,
    input  logic [S-1:0] fill_offset,
    input  logic [N-1:0] mem_readdata,
    input  logic         mem_readdatavalid,
    output logic         busy,
    output logic         crit_valid,
    output logic [N-1:0] crit_word,
    output logic         line_valid,
    input  logic         line_ready,
    output logic [W-1:0] line_data,
    output logic         overrun
);

    // count runs 0..M-1 during a fill; the beat taken at LastBeat completes the line.
    localparam logic [S:0] LastBeat = (S + 1)'(M - 1);
    localparam logic [S:0] CountOne = (S + 1)'(1);

    fill_state_e    state_q, state_d;
    logic [S-1:0]   base_q, base_d;
    logic [S:0]     count_q, count_d;
    logic [N-1:0]   crit_word_q;
    logic           crit_valid_q, crit_valid_d;
    logic           overrun_q, overrun_d;
    logic [W-1:0]   line_q;

    logic           beat_we;
    logic           crit_load;
    logic [S-1:0]   slot;
    logic [M-1:0]   slot_en;

    // Wrapping slot: S-bit add truncates, so the burst wraps around the line for free.
    assign slot = base_q + count_q[S-1:0];

    tiger_icache_line_demux #(
        .M (M),
        .S (S)
    ) u_line_demux (
        .slot (slot),
        .we   (beat_we),
        .en   (slot_en)
    );

    // Next-state logic: fill sequencing, beat acceptance and handshake.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        count_d      = count_q;
        beat_we      = 1'b0;
        crit_load    = 1'b0;
        crit_valid_d = 1'b0;
        // Any beat seen while not filling is dropped but flagged.
        overrun_d    = mem_readdatavalid && (state_q != StFill);

        unique case (state_q)
            StIdle: begin
                if (fill_start) begin
                    base_d  = fill_offset;
                    count_d = '0;
                    state_d = StFill;
                end
            end
            StFill: begin
                if (mem_readdatavalid) begin
                    beat_we      = 1'b1;
                    crit_load    = (count_q == '0);
                    crit_valid_d = (count_q == '0);
                    count_d      = count_q + CountOne;
                    if (count_q == LastBeat) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (line_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
        if (!csi_clockreset_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Fill bookkeeping plus registered critical-word and overrun outputs.
    always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
        if (!csi_clockreset_reset_n) begin
            base_q       <= '0;
            count_q      <= '0;
            crit_word_q  <= '0;
            crit_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            base_q       <= base_d;
            count_q      <= count_d;
            crit_valid_q <= crit_valid_d;
            overrun_q    <= overrun_d;
            if (crit_load) begin
                crit_word_q <= mem_readdata;
            end
        end
    end

    // Line register: each beat lands in the word slot selected by the demux.
    always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
        if (!csi_clockreset_reset_n) begin
            line_q <= '0;
        end else begin
            for (int unsigned k = 0; k < M; k++) begin
                if (slot_en[k]) begin
                    line_q[k*N +: N] <= mem_readdata;
                end
            end
        end
    end

    // Every output comes straight from a register.
    assign busy       = (state_q != StIdle);
    assign line_valid = (state_q == StDone);
    assign crit_valid = crit_valid_q;
    assign crit_word  = crit_word_q;
    assign overrun    = overrun_q;
    assign line_data  = line_q;

endmodule

// File: tb/tb_tiger_icache_fill_buffer.sv
// Self-checking bench for tiger_icache_fill_buffer with a line-assembly reference model.
module tb_tiger_icache_fill_buffer;

    localparam int N = 32;
    localparam int M = 8;
    localparam int S = 3;
    localparam int W = M * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fill_start;
    logic [S-1:0] fill_offset;
    logic [N-1:0] mem_readdata;
    logic         mem_readdatavalid;
    logic         busy;
    logic         crit_valid;
    logic [N-1:0] crit_word;
    logic         line_valid;
    logic         line_ready;
    logic [W-1:0] line_data;
    logic         overrun;

    always #5 clk = ~clk;

    tiger_icache_fill_buffer dut (
        .csi_clockreset_clk     (clk),
        .csi_clockreset_reset_n (rst_n),
        .fill_start             (fill_start),
        .fill_offset            (fill_offset),
        .mem_readdata           (mem_readdata),
        .mem_readdatavalid      (mem_readdatavalid),
        .busy                   (busy),
        .crit_valid             (crit_valid),
        .crit_word              (crit_word),
        .line_valid             (line_valid),
        .line_ready             (line_ready),
        .line_data              (line_data),
        .overrun                (overrun)
    );

    int          checks = 0;
    int          failures = 0;

    // Burst contents in arrival order and idle cycles inserted before each beat.
    logic [N-1:0] beats [M];
    int           gap   [M];

    // Observations gathered while a fill runs.
    int           cyc;
    int           crit_pulses;
    int           overrun_pulses;
    int           cycles_to_valid;
    bit           busy_dropped;
    logic [N-1:0] crit_seen;

    // Reference: beat i of a burst starting at word off belongs in word (off + i) mod M.
    function automatic logic [W-1:0] expected_line(input int off);
        logic [W-1:0] l;
        l = '0;
        for (int i = 0; i < M; i++) begin
            l[((off + i) % M) * N +: N] = beats[i];
        end
        return l;
    endfunction

    task automatic observe();
        if (crit_valid === 1'b1) begin
            crit_pulses++;
            crit_seen = crit_word;
        end
        if (overrun === 1'b1) overrun_pulses++;
        if (busy !== 1'b1) busy_dropped = 1'b1;
    endtask

    // Advance to the next falling edge and record what the DUT shows in that cycle.
    task automatic step();
        @(negedge clk);
        cyc++;
        observe();
    endtask

    task automatic clear_obs();
        crit_pulses    = 0;
        overrun_pulses = 0;
        busy_dropped   = 1'b0;
        crit_seen      = 'x;
    endtask

    // Cycle 0 carries fill_start; then beats[] with gap[] idle cycles before each.
    task automatic drive_fill(input int off, input bit stray);
        clear_obs();
        cyc             = 0;
        cycles_to_valid = -1;
        fill_start        = 1'b1;
        fill_offset       = S'(off);
        mem_readdatavalid = stray;
        mem_readdata      = $urandom;
        step();
        fill_start        = 1'b0;
        mem_readdatavalid = 1'b0;
        for (int i = 0; i < M; i++) begin
            for (int g = 0; g < gap[i]; g++) step();
            mem_readdatavalid = 1'b1;
            mem_readdata      = beats[i];
            step();
            mem_readdatavalid = 1'b0;
        end
        while (line_valid !== 1'b1 && cyc < 64) step();
        if (line_valid === 1'b1) cycles_to_valid = cyc;
    endtask

    // Keep line_ready low for hold cycles, then complete the handshake.
    task automatic accept_line(input int hold, input logic [W-1:0] exp);
        line_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            step();
            checks++;
            if (line_valid !== 1'b1 || line_data !== exp) begin
                failures++;
                $display("FAIL hold_stable: valid=%b data=%h expected valid=1 data=%h",
                         line_valid, line_data, exp);
            end
        end
        line_ready = 1'b1;
        step();
        line_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || line_valid !== 1'b0) begin
            failures++;
            $display("FAIL release: busy=%b line_valid=%b expected 0 0", busy, line_valid);
        end
        checks++;
        if (line_data !== exp) begin
            failures++;
            $display("FAIL line_kept: got %h expected %h", line_data, exp);
        end
    endtask

    task automatic set_beats_random();
        for (int i = 0; i < M; i++) begin
            beats[i] = $urandom;
            gap[i]   = 0;
        end
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        fill_start        = 1'b0;
        fill_offset       = '0;
        mem_readdata      = '0;
        mem_readdatavalid = 1'b0;
        line_ready        = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, crit_valid, line_valid, overrun} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {busy, crit_valid, line_valid, overrun});
        end
        checks++;
        if (crit_word !== '0) begin
            failures++;
            $display("FAIL reset_crit_word: got %h expected 0", crit_word);
        end
        checks++;
        if (line_data !== '0) begin
            failures++;
            $display("FAIL reset_line: got %h expected 0", line_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned();
        logic [W-1:0] exp;
        for (int i = 0; i < M; i++) begin
            beats[i] = 32'h100 + i;
            gap[i]   = 0;
        end
        exp = expected_line(0);
        drive_fill(0, 1'b0);
        checks++;
        if (cycles_to_valid !== 9) begin
            failures++;
            $display("FAIL aligned_latency: got %0d expected 9", cycles_to_valid);
        end
        checks++;
        if (crit_pulses !== 1 || crit_seen !== 32'h100) begin
            failures++;
            $display("FAIL aligned_crit: pulses=%0d word=%h expected 1 00000100",
                     crit_pulses, crit_seen);
        end
        checks++;
        if (crit_word !== 32'h100) begin
            failures++;
            $display("FAIL aligned_crit_hold: got %h expected 00000100", crit_word);
        end
        checks++;
        if (line_data !== exp) begin
            failures++;
            $display("FAIL aligned_line: got %h expected %h", line_data, exp);
        end
        checks++;
        if (overrun_pulses !== 0 || busy_dropped) begin
            failures++;
            $display("FAIL aligned_flags: overruns=%0d busy_dropped=%0d expected 0 0",
                     overrun_pulses, busy_dropped);
        end
        accept_line(0, exp);
    endtask

    task automatic test_wrapped();
        logic [W-1:0] exp;
        for (int i = 0; i < M; i++) begin
            beats[i] = 32'hA0 + i;
            gap[i]   = 0;
        end
        exp = expected_line(5);
        drive_fill(5, 1'b0);
        checks++;
        if (line_data !== exp) begin
            failures++;
            $display("FAIL wrapped_line: got %h expected %h", line_data, exp);
        end
        checks++;
        if (line_data[5*N +: N] !== 32'hA0 || line_data[4*N +: N] !== 32'hA7) begin
            failures++;
            $display("FAIL wrapped_slots: slot5=%h slot4=%h expected a0 a7",
                     line_data[5*N +: N], line_data[4*N +: N]);
        end
        checks++;
        if (crit_seen !== 32'hA0 || crit_pulses !== 1) begin
            failures++;
            $display("FAIL wrapped_crit: word=%h pulses=%0d expected a0 1", crit_seen, crit_pulses);
        end
        accept_line(1, exp);
    endtask

    task automatic test_gapped();
        logic [W-1:0] exp;
        int           off;
        set_beats_random();
        gap[3] = 3;
        off    = $urandom_range(0, M - 1);
        exp    = expected_line(off);
        drive_fill(off, 1'b0);
        checks++;
        if (cycles_to_valid !== 12) begin
            failures++;
            $display("FAIL gapped_latency: got %0d expected 12", cycles_to_valid);
        end
        checks++;
        if (busy_dropped) begin
            failures++;
            $display("FAIL gapped_busy: busy dropped during fill, expected held high");
        end
        checks++;
        if (line_data !== exp) begin
            failures++;
            $display("FAIL gapped_line: got %h expected %h", line_data, exp);
        end
        accept_line(2, exp);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp;
        int           off;
        set_beats_random();
        off = $urandom_range(0, M - 1);
        exp = expected_line(off);
        drive_fill(off, 1'b0);
        clear_obs();
        line_ready = 1'b0;
        for (int h = 0; h < 10; h++) begin
            fill_start        = (h == 2);
            fill_offset       = S'(off + 1);
            mem_readdatavalid = (h == 4);
            mem_readdata      = $urandom;
            step();
            checks++;
            if (line_valid !== 1'b1 || line_data !== exp) begin
                failures++;
                $display("FAIL bp_stable: valid=%b data=%h expected valid=1 data=%h",
                         line_valid, line_data, exp);
            end
        end
        fill_start        = 1'b0;
        mem_readdatavalid = 1'b0;
        checks++;
        if (overrun_pulses !== 1) begin
            failures++;
            $display("FAIL bp_overrun: got %0d cycles expected 1", overrun_pulses);
        end
        checks++;
        if (crit_pulses !== 0) begin
            failures++;
            $display("FAIL bp_crit: got %0d pulses expected 0", crit_pulses);
        end
        accept_line(0, exp);
    endtask

    task automatic test_reset_mid_fill();
        logic [W-1:0] exp;
        set_beats_random();
        cyc         = 0;
        fill_start  = 1'b1;
        fill_offset = S'($urandom_range(0, M - 1));
        step();
        fill_start  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = beats[i];
            step();
        end
        mem_readdatavalid = 1'b0;
        checks++;
        if (crit_word !== beats[0]) begin
            failures++;
            $display("FAIL midfill_crit: got %h expected %h", crit_word, beats[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, crit_valid, line_valid, overrun} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset_flags: got %b expected 0000",
                     {busy, crit_valid, line_valid, overrun});
        end
        checks++;
        if (crit_word !== '0 || line_data !== '0) begin
            failures++;
            $display("FAIL async_reset_data: crit=%h line=%h expected 0 0", crit_word, line_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_beats_random();
        exp = expected_line(2);
        drive_fill(2, 1'b0);
        checks++;
        if (line_data !== exp || cycles_to_valid !== 9) begin
            failures++;
            $display("FAIL post_reset_fill: line=%h cycles=%0d expected %h 9",
                     line_data, cycles_to_valid, exp);
        end
        checks++;
        if (crit_seen !== beats[0]) begin
            failures++;
            $display("FAIL post_reset_crit: got %h expected %h", crit_seen, beats[0]);
        end
        accept_line(0, exp);
    endtask

    task automatic test_same_cycle();
        logic [W-1:0] exp;
        int           off;
        set_beats_random();
        off = $urandom_range(0, M - 1);
        exp = expected_line(off);
        drive_fill(off, 1'b1);
        checks++;
        if (overrun_pulses !== 1) begin
            failures++;
            $display("FAIL same_cycle_overrun: got %0d expected 1", overrun_pulses);
        end
        checks++;
        if (line_data !== exp || cycles_to_valid !== 9) begin
            failures++;
            $display("FAIL same_cycle_line: line=%h cycles=%0d expected %h 9",
                     line_data, cycles_to_valid, exp);
        end
        checks++;
        if (crit_seen !== beats[0]) begin
            failures++;
            $display("FAIL same_cycle_crit: got %h expected %h", crit_seen, beats[0]);
        end
        accept_line(1, exp);
    endtask

    task automatic test_random_fills();
        logic [W-1:0] exp;
        int           off;
        int           total_gap;
        for (int r = 0; r < 6; r++) begin
            total_gap = 0;
            for (int i = 0; i < M; i++) begin
                beats[i] = $urandom;
                gap[i]   = (i == 0) ? 0 : $urandom_range(0, 2);
                total_gap += gap[i];
            end
            off = $urandom_range(0, M - 1);
            exp = expected_line(off);
            drive_fill(off, 1'b0);
            checks++;
            if (line_data !== exp) begin
                failures++;
                $display("FAIL random_line[%0d]: got %h expected %h", r, line_data, exp);
            end
            checks++;
            if (cycles_to_valid !== 9 + total_gap) begin
                failures++;
                $display("FAIL random_latency[%0d]: got %0d expected %0d",
                         r, cycles_to_valid, 9 + total_gap);
            end
            checks++;
            if (crit_pulses !== 1 || crit_seen !== beats[0] || overrun_pulses !== 0) begin
                failures++;
                $display("FAIL random_crit[%0d]: pulses=%0d word=%h overruns=%0d expected 1 %h 0",
                         r, crit_pulses, crit_seen, overrun_pulses, beats[0]);
            end
            accept_line($urandom_range(0, 3), exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_aligned();
        test_wrapped();
        test_gapped();
        test_backpressure();
        test_reset_mid_fill();
        test_same_cycle();
        test_random_fills();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
